// File: rtl/skin_region_stats_if.sv
// Pixel-in / statistics-out bundle for skin_region_stats.
// master: the detector/control side that drives pixels and accepts results.
// slave: the statistics block.
interface skin_region_stats_if #(
    parameter int DATAIN_WIDTH = 32,
    parameter int COORD_WIDTH  = 11,
    parameter int COUNT_WIDTH  = 20
);
    logic                    datain_valid;
    logic [DATAIN_WIDTH-1:0] datain;
    logic                    datain_sof;
    logic                    datain_ready;
    logic [7:0]              thresh;
    logic                    result_valid;
    logic                    result_ready;
    logic [COUNT_WIDTH-1:0]  skin_count;
    logic [COORD_WIDTH-1:0]  min_x;
    logic [COORD_WIDTH-1:0]  max_x;
    logic [COORD_WIDTH-1:0]  min_y;
    logic [COORD_WIDTH-1:0]  max_y;
    logic                    result_empty;
    logic                    resync_err;

    modport master (
        output datain_valid, datain, datain_sof, thresh, result_ready,
        input  datain_ready, result_valid, skin_count, min_x, max_x, min_y, max_y,
               result_empty, resync_err
    );

    modport slave (
        input  datain_valid, datain, datain_sof, thresh, result_ready,
        output datain_ready, result_valid, skin_count, min_x, max_x, min_y, max_y,
               result_empty, resync_err
    );
endinterface

// File: rtl/skin_region_stats.sv
// Per-frame skin pixel count and bounding box from the detector's thresholded score stream.
// Latency: result_valid one cycle after the last pixel of a frame is accepted.
// Backpressure: stalls input (datain_ready=0) while a result waits for result_ready.
module skin_region_stats #(
    parameter int DATAIN_WIDTH = 32,
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int COORD_WIDTH  = 11,
    parameter int COUNT_WIDTH  = 20
) (
    input logic clk,
    input logic rst_n,
    skin_region_stats_if.slave bus
);
    typedef enum logic {ACCUM, REPORT} state_t;

    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(IMG_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [COORD_WIDTH-1:0] C_ONE  = COORD_WIDTH'(1);

    state_t                 state, state_n;
    logic                   rdy_q, rdy_n;
    logic                   rv_q, rv_n;
    logic                   resync_q, resync_n;
    logic [COORD_WIDTH-1:0] x_q, x_n, y_q, y_n;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_n;
    logic                   any_q, any_n;
    logic [COORD_WIDTH-1:0] mnx_q, mnx_n, mxx_q, mxx_n, mny_q, mny_n, mxy_q, mxy_n;
    logic [COUNT_WIDTH-1:0] o_cnt_q, o_cnt_n;
    logic [COORD_WIDTH-1:0] o_mnx_q, o_mnx_n, o_mxx_q, o_mxx_n;
    logic [COORD_WIDTH-1:0] o_mny_q, o_mny_n, o_mxy_q, o_mxy_n;
    logic                   o_empty_q, o_empty_n;

    // Per-beat pixel evaluation; an unexpected sof rebases the beat to (0,0) of a fresh frame.
    logic                   accept, restart, is_skin, last_px, base_any, new_any;
    logic [COORD_WIDTH-1:0] eff_x, eff_y;
    logic [COORD_WIDTH-1:0] base_mnx, base_mxx, base_mny, base_mxy;
    logic [COORD_WIDTH-1:0] upd_mnx, upd_mxx, upd_mny, upd_mxy;
    logic [COUNT_WIDTH-1:0] new_cnt;
    logic                   unused_hi;

    assign unused_hi = ^bus.datain[DATAIN_WIDTH-1:8];
    assign accept    = bus.datain_valid && rdy_q;
    assign restart   = bus.datain_sof && ((x_q != '0) || (y_q != '0));
    assign is_skin   = bus.datain[7:0] >= bus.thresh;
    assign eff_x     = restart ? '0 : x_q;
    assign eff_y     = restart ? '0 : y_q;
    assign last_px   = (eff_x == X_LAST) && (eff_y == Y_LAST);
    assign base_any  = restart ? 1'b0 : any_q;
    assign base_mnx  = restart ? '0 : mnx_q;
    assign base_mxx  = restart ? '0 : mxx_q;
    assign base_mny  = restart ? '0 : mny_q;
    assign base_mxy  = restart ? '0 : mxy_q;
    assign new_cnt   = (restart ? '0 : cnt_q) + {{(COUNT_WIDTH-1){1'b0}}, is_skin};
    assign new_any   = base_any | is_skin;
    assign upd_mnx   = !is_skin ? base_mnx : (!base_any || eff_x < base_mnx) ? eff_x : base_mnx;
    assign upd_mxx   = !is_skin ? base_mxx : (!base_any || eff_x > base_mxx) ? eff_x : base_mxx;
    assign upd_mny   = !is_skin ? base_mny : (!base_any || eff_y < base_mny) ? eff_y : base_mny;
    assign upd_mxy   = !is_skin ? base_mxy : (!base_any || eff_y > base_mxy) ? eff_y : base_mxy;

    // Next-state and datapath decisions for the ACCUM/REPORT controller.
    always_comb begin
        state_n   = state;
        rv_n      = rv_q;
        resync_n  = resync_q;
        x_n       = x_q;
        y_n       = y_q;
        cnt_n     = cnt_q;
        any_n     = any_q;
        mnx_n     = mnx_q;
        mxx_n     = mxx_q;
        mny_n     = mny_q;
        mxy_n     = mxy_q;
        o_cnt_n   = o_cnt_q;
        o_mnx_n   = o_mnx_q;
        o_mxx_n   = o_mxx_q;
        o_mny_n   = o_mny_q;
        o_mxy_n   = o_mxy_q;
        o_empty_n = o_empty_q;
        case (state)
            ACCUM: begin
                if (accept) begin
                    if (restart) resync_n = 1'b1;
                    if (last_px) begin
                        o_cnt_n   = new_cnt;
                        o_mnx_n   = new_any ? upd_mnx : '0;
                        o_mxx_n   = new_any ? upd_mxx : '0;
                        o_mny_n   = new_any ? upd_mny : '0;
                        o_mxy_n   = new_any ? upd_mxy : '0;
                        o_empty_n = !new_any;
                        rv_n      = 1'b1;
                        state_n   = REPORT;
                        x_n       = '0;
                        y_n       = '0;
                        cnt_n     = '0;
                        any_n     = 1'b0;
                        mnx_n     = '0;
                        mxx_n     = '0;
                        mny_n     = '0;
                        mxy_n     = '0;
                    end else begin
                        cnt_n = new_cnt;
                        any_n = new_any;
                        mnx_n = upd_mnx;
                        mxx_n = upd_mxx;
                        mny_n = upd_mny;
                        mxy_n = upd_mxy;
                        if (eff_x == X_LAST) begin
                            x_n = '0;
                            y_n = eff_y + C_ONE;
                        end else begin
                            x_n = eff_x + C_ONE;
                            y_n = eff_y;
                        end
                    end
                end
            end
            REPORT: begin
                if (bus.result_ready) begin
                    rv_n    = 1'b0;
                    state_n = ACCUM;
                end
            end
            default: state_n = ACCUM;
        endcase
        rdy_n = (state_n == ACCUM);
    end

    // State, accumulator and result registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            rdy_q     <= 1'b0;
            rv_q      <= 1'b0;
            resync_q  <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            any_q     <= 1'b0;
            mnx_q     <= '0;
            mxx_q     <= '0;
            mny_q     <= '0;
            mxy_q     <= '0;
            o_cnt_q   <= '0;
            o_mnx_q   <= '0;
            o_mxx_q   <= '0;
            o_mny_q   <= '0;
            o_mxy_q   <= '0;
            o_empty_q <= 1'b0;
        end else begin
            state     <= state_n;
            rdy_q     <= rdy_n;
            rv_q      <= rv_n;
            resync_q  <= resync_n;
            x_q       <= x_n;
            y_q       <= y_n;
            cnt_q     <= cnt_n;
            any_q     <= any_n;
            mnx_q     <= mnx_n;
            mxx_q     <= mxx_n;
            mny_q     <= mny_n;
            mxy_q     <= mxy_n;
            o_cnt_q   <= o_cnt_n;
            o_mnx_q   <= o_mnx_n;
            o_mxx_q   <= o_mxx_n;
            o_mny_q   <= o_mny_n;
            o_mxy_q   <= o_mxy_n;
            o_empty_q <= o_empty_n;
        end
    end

    assign bus.datain_ready = rdy_q;
    assign bus.result_valid = rv_q;
    assign bus.resync_err   = resync_q;
    assign bus.skin_count   = o_cnt_q;
    assign bus.min_x        = o_mnx_q;
    assign bus.max_x        = o_mxx_q;
    assign bus.min_y        = o_mny_q;
    assign bus.max_y        = o_mxy_q;
    assign bus.result_empty = o_empty_q;
endmodule
